// File: rtl/decode_hazard_ctrl_if.sv
// Decode <-> hazard controller interface.
// Carries the pre-decoded operand fields, writeback notifications and branch
// resolve from the pipeline, and the issue/stall/status results back to Decode.
//   master : Decode/pipeline side (drives I_*, observes O_*)
//   slave  : decode_hazard_ctrl (observes I_*, drives O_*)
interface decode_hazard_ctrl_if;
  logic       I_IssueValid;
  logic [5:0] I_Src1Idx;
  logic       I_Src1Use;
  logic       I_Src1Vec;
  logic [5:0] I_Src2Idx;
  logic       I_Src2Use;
  logic       I_Src2Vec;
  logic [5:0] I_DestIdx;
  logic       I_DestWrite;
  logic       I_DestVec;
  logic       I_IsBranch;
  logic       I_NeedsCC;
  logic       I_WriteBackEnable;
  logic [5:0] I_WriteBackRegIdx;
  logic       I_VWriteBackEnable;
  logic [5:0] I_VWriteBackRegIdx;
  logic       I_BranchResolve;
  logic       O_Issue;
  logic       O_DepStall;
  logic       O_BranchStall;
  logic [6:0] O_Outstanding;
  logic       O_ScoreErr;

  modport master (
    output I_IssueValid, I_Src1Idx, I_Src1Use, I_Src1Vec,
           I_Src2Idx, I_Src2Use, I_Src2Vec,
           I_DestIdx, I_DestWrite, I_DestVec, I_IsBranch, I_NeedsCC,
           I_WriteBackEnable, I_WriteBackRegIdx,
           I_VWriteBackEnable, I_VWriteBackRegIdx, I_BranchResolve,
    input  O_Issue, O_DepStall, O_BranchStall, O_Outstanding, O_ScoreErr
  );

  modport slave (
    input  I_IssueValid, I_Src1Idx, I_Src1Use, I_Src1Vec,
           I_Src2Idx, I_Src2Use, I_Src2Vec,
           I_DestIdx, I_DestWrite, I_DestVec, I_IsBranch, I_NeedsCC,
           I_WriteBackEnable, I_WriteBackRegIdx,
           I_VWriteBackEnable, I_VWriteBackRegIdx, I_BranchResolve,
    output O_Issue, O_DepStall, O_BranchStall, O_Outstanding, O_ScoreErr
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage scoreboard and branch stall sequencer.
// Tracks pending destinations of the scalar and vector register files,
// decides whether the decoded instruction may issue (RAW, WAW and
// condition-code hazards, with same-cycle writeback bypass), and holds Fetch
// from branch issue until BR_DRAIN cycles after the branch resolves.
//   I_CLOCK : clock, posedge
//   I_RESET : asynchronous active-high reset
//   bus     : decode_hazard_ctrl_if.slave (operand fields, writebacks,
//             resolve in; O_Issue/O_DepStall combinational, O_BranchStall,
//             O_Outstanding, O_ScoreErr registered)
module decode_hazard_ctrl #(
  parameter int unsigned NUM_RF   = 16,
  parameter int unsigned NUM_VRF  = 64,
  parameter int unsigned BR_DRAIN = 2
) (
  input logic                 I_CLOCK,
  input logic                 I_RESET,
  decode_hazard_ctrl_if.slave bus
);

  localparam int unsigned SW = $clog2(NUM_RF);
  localparam int unsigned VW = $clog2(NUM_VRF);

  typedef enum logic [1:0] {S_RUN, S_BR_WAIT, S_BR_DRAIN} state_t;

  state_t             state;
  logic [2:0]         drain_cnt;
  logic [NUM_RF-1:0]  s_pend, s_eff, s_next;
  logic [NUM_VRF-1:0] v_pend, v_eff, v_next;
  logic               src1_haz, src2_haz, dest_haz, cc_haz, hazard, issue;
  logic               s_set, v_set, s_wb_err, v_wb_err;
  logic [6:0]         pend_count;
  logic               branch_stall_q, score_err_q;
  logic [6:0]         outstanding_q;

  // Scalar paths only look at the low index bits; the rest is ignored.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{bus.I_Src1Idx[5:SW], bus.I_Src2Idx[5:SW],
                             bus.I_DestIdx[5:SW], bus.I_WriteBackRegIdx[5:SW]};

  // Pending bits as seen this cycle: a writeback landing now releases readers.
  always_comb begin
    s_eff = s_pend;
    v_eff = v_pend;
    if (bus.I_WriteBackEnable)  s_eff[bus.I_WriteBackRegIdx[SW-1:0]]  = 1'b0;
    if (bus.I_VWriteBackEnable) v_eff[bus.I_VWriteBackRegIdx[VW-1:0]] = 1'b0;
  end

  always_comb begin
    src1_haz = bus.I_Src1Use & (bus.I_Src1Vec ? v_eff[bus.I_Src1Idx[VW-1:0]]
                                              : s_eff[bus.I_Src1Idx[SW-1:0]]);
    src2_haz = bus.I_Src2Use & (bus.I_Src2Vec ? v_eff[bus.I_Src2Idx[VW-1:0]]
                                              : s_eff[bus.I_Src2Idx[SW-1:0]]);
    dest_haz = bus.I_DestWrite & (bus.I_DestVec ? v_eff[bus.I_DestIdx[VW-1:0]]
                                                : s_eff[bus.I_DestIdx[SW-1:0]]);
    cc_haz   = bus.I_NeedsCC & (|s_eff);
    hazard   = src1_haz | src2_haz | dest_haz | cc_haz;
    issue    = bus.I_IssueValid & ~hazard & (state == S_RUN);
  end

  assign bus.O_Issue    = issue;
  assign bus.O_DepStall = bus.I_IssueValid & hazard & (state == S_RUN);

  // Next pend state: writeback clears first, then a new producer sets, so
  // the set wins on a collision. Writeback to an idle register is an error
  // unless the issuing instruction is claiming that register this cycle.
  always_comb begin
    s_set    = issue & bus.I_DestWrite & ~bus.I_DestVec;
    v_set    = issue & bus.I_DestWrite & bus.I_DestVec;
    s_next   = s_pend;
    v_next   = v_pend;
    s_wb_err = 1'b0;
    v_wb_err = 1'b0;
    if (bus.I_WriteBackEnable) begin
      s_next[bus.I_WriteBackRegIdx[SW-1:0]] = 1'b0;
      s_wb_err = ~s_pend[bus.I_WriteBackRegIdx[SW-1:0]] &
                 ~(s_set & (bus.I_DestIdx[SW-1:0] == bus.I_WriteBackRegIdx[SW-1:0]));
    end
    if (bus.I_VWriteBackEnable) begin
      v_next[bus.I_VWriteBackRegIdx[VW-1:0]] = 1'b0;
      v_wb_err = ~v_pend[bus.I_VWriteBackRegIdx[VW-1:0]] &
                 ~(v_set & (bus.I_DestIdx[VW-1:0] == bus.I_VWriteBackRegIdx[VW-1:0]));
    end
    if (s_set) s_next[bus.I_DestIdx[SW-1:0]] = 1'b1;
    if (v_set) v_next[bus.I_DestIdx[VW-1:0]] = 1'b1;
  end

  always_comb begin
    pend_count = '0;
    for (int unsigned i = 0; i < NUM_RF; i++)  pend_count = pend_count + 7'(s_next[i]);
    for (int unsigned i = 0; i < NUM_VRF; i++) pend_count = pend_count + 7'(v_next[i]);
  end

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      s_pend         <= '0;
      v_pend         <= '0;
      state          <= S_RUN;
      drain_cnt      <= '0;
      branch_stall_q <= 1'b0;
      outstanding_q  <= '0;
      score_err_q    <= 1'b0;
    end else begin
      s_pend        <= s_next;
      v_pend        <= v_next;
      outstanding_q <= pend_count;
      if (s_wb_err | v_wb_err) score_err_q <= 1'b1;
      case (state)
        S_RUN: begin
          if (issue & bus.I_IsBranch) begin
            state          <= S_BR_WAIT;
            branch_stall_q <= 1'b1;
          end
        end
        S_BR_WAIT: begin
          if (bus.I_BranchResolve) begin
            state     <= S_BR_DRAIN;
            drain_cnt <= 3'(BR_DRAIN - 1);
          end
        end
        S_BR_DRAIN: begin
          if (drain_cnt == '0) begin
            state          <= S_RUN;
            branch_stall_q <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: begin
          state          <= S_RUN;
          branch_stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_BranchStall = branch_stall_q;
  assign bus.O_Outstanding = outstanding_q;
  assign bus.O_ScoreErr    = score_err_q;

endmodule
